// File: rtl/fe_mul_column_acc_pkg.sv
// Shared constants, state encoding and product-register layout for the column-accumulating multiplier.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fe_mul_column_acc_pkg;

  localparam int LIMB_W    = 51;
  localparam int NLIMBS    = 5;
  localparam int ACC_W     = 2*LIMB_W + 3;
  localparam int PROD_W    = 2*LIMB_W;
  localparam int NCOLS     = 2*NLIMBS - 1;
  localparam int MUL_STEPS = NLIMBS*NLIMBS;
  localparam int K_W       = $clog2(MUL_STEPS);
  localparam int IDX_W     = $clog2(NLIMBS);
  localparam int COL_W     = $clog2(NCOLS);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(MUL_STEPS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // One registered partial product tagged with its destination column.
  typedef struct packed {
    logic              vld;
    logic [COL_W-1:0]  col;
    logic [PROD_W-1:0] dat;
  } prod_t;

  // Extract limb n from a packed field element.
  function automatic logic [LIMB_W-1:0] limb_of(input logic [NLIMBS*LIMB_W-1:0] v, input int n);
    return v[n*LIMB_W +: LIMB_W];
  endfunction

endpackage

// File: rtl/mul_schedule_rom.sv
// Maps schoolbook step k (0..24) to limb indices (i,j), row-major: i = k / 5, j = k % 5.
// Latency: combinational.
// Backpressure: none; caller owns sequencing.
module mul_schedule_rom
  import fe_mul_column_acc_pkg::*;
(
  input  logic [K_W-1:0]   k,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j
);

  // Constant lookup; out-of-range steps fall back to (0,0) and are never issued.
  always_comb begin
    i = '0;
    j = '0;
    for (int ii = 0; ii < NLIMBS; ii++) begin
      for (int jj = 0; jj < NLIMBS; jj++) begin
        if (int'(k) == ii*NLIMBS + jj) begin
          i = IDX_W'(ii);
          j = IDX_W'(jj);
        end
      end
    end
  end

endmodule

// File: rtl/fe_mul_column_acc.sv
// Sequential schoolbook multiplier: 25 limb products accumulated into 9 unreduced column sums, streamed out.
// Latency: first out_valid 27 cycles after accept; fixed, operand-independent.
// Backpressure: DRAIN holds out_col/out_data/out_last while out_ready is low; in_ready low until column 8 leaves.
module fe_mul_column_acc
  import fe_mul_column_acc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLIMBS*LIMB_W-1:0] a_in,
  input  logic [NLIMBS*LIMB_W-1:0] b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COL_W-1:0]         out_col,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy
);

  // The schedule ROM only covers a 5x5 limb product.
  if (NLIMBS != 5) begin : g_cfg_err
    $error("fe_mul_column_acc: NLIMBS must be 5");
  end

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LIMB_W-1:0]   a_q [NLIMBS];
  logic [LIMB_W-1:0]   a_d [NLIMBS];
  logic [LIMB_W-1:0]   b_q [NLIMBS];
  logic [LIMB_W-1:0]   b_d [NLIMBS];
  logic [ACC_W-1:0]    acc_q [NCOLS];
  logic [ACC_W-1:0]    acc_d [NCOLS];
  prod_t               prod_q, prod_d;
  logic [IDX_W-1:0]    rom_i, rom_j;

  mul_schedule_rom u_rom (
    .k (k_q),
    .i (rom_i),
    .j (rom_j)
  );

  // Ready only in IDLE and never during the reset cycle itself.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_col   = col_q;
  assign out_data  = out_valid ? acc_q[col_q] : '0;
  assign out_last  = out_valid && (col_q == COL_LAST);

  // Next-state, operand latch, product pipeline and column accumulation.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    col_d   = col_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = '0;

    // Product registered last cycle lands in its column now.
    if (prod_q.vld) begin
      acc_d[prod_q.col] = acc_q[prod_q.col] + ACC_W'(prod_q.dat);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          for (int n = 0; n < NLIMBS; n++) begin
            a_d[n] = limb_of(a_in, n);
            b_d[n] = limb_of(b_in, n);
          end
          for (int c = 0; c < NCOLS; c++) acc_d[c] = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        prod_d.vld = 1'b1;
        prod_d.col = COL_W'(rom_i) + COL_W'(rom_j);
        prod_d.dat = PROD_W'(a_q[rom_i]) * PROD_W'(b_q[rom_j]);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_FLUSH;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        col_d   = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_IDLE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous clear; an abort discards every partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      col_q   <= '0;
      prod_q  <= '0;
      for (int n = 0; n < NLIMBS; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
      end
      for (int c = 0; c < NCOLS; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_fe_mul_column_acc.sv
// Self-checking bench: column sums compared against a plain-arithmetic schoolbook model.
// Latency: checks first out_valid lands exactly 27 cycles after accept.
// Backpressure: stalls out_ready on chosen columns and checks outputs hold.
module tb_fe_mul_column_acc;
  import fe_mul_column_acc_pkg::*;

  typedef logic [LIMB_W-1:0] limbs_t [NLIMBS];

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [NLIMBS*LIMB_W-1:0] a_in;
  logic [NLIMBS*LIMB_W-1:0] b_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [COL_W-1:0]         out_col;
  logic [ACC_W-1:0]         out_data;
  logic                     out_last;
  logic                     busy;

  int n_chk  = 0;
  int n_fail = 0;

  fe_mul_column_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LIMB_W-1:0] rnd_limb();
    return LIMB_W'({$urandom, $urandom});
  endfunction

  function automatic logic [NLIMBS*LIMB_W-1:0] rnd_fe();
    logic [NLIMBS*LIMB_W-1:0] v;
    for (int n = 0; n < NLIMBS; n++) v[n*LIMB_W +: LIMB_W] = rnd_limb();
    return v;
  endfunction

  // One full operation: accept, latency, nine columns with optional stall, return to IDLE.
  task automatic run_op(input limbs_t a, input limbs_t b, input int stall_col,
                        input int stall_n, input bit hold_valid);
    logic [127:0]     exp [NCOLS];
    logic [COL_W-1:0] held_col;
    logic [ACC_W-1:0] held_dat;
    int lat;
    int w;
    for (int c = 0; c < NCOLS; c++) exp[c] = '0;
    for (int i = 0; i < NLIMBS; i++)
      for (int j = 0; j < NLIMBS; j++)
        exp[i+j] = exp[i+j] + 128'(a[i]) * 128'(b[j]);

    @(negedge clk);
    for (int n = 0; n < NLIMBS; n++) begin
      a_in[n*LIMB_W +: LIMB_W] = a[n];
      b_in[n*LIMB_W +: LIMB_W] = b[n];
    end
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));

    @(negedge clk);
    lat = 1;
    if (!hold_valid) in_valid = 1'b0;
    a_in = rnd_fe();
    b_in = rnd_fe();
    chk("busy_after_accept", 128'(busy), 128'(1));
    chk("in_ready_after_accept", 128'(in_ready), 128'(0));
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", 128'(lat), 128'(27));

    for (int c = 0; c < NCOLS; c++) begin
      chk($sformatf("col%0d_valid", c), 128'(out_valid), 128'(1));
      chk($sformatf("col%0d_index", c), 128'(out_col), 128'(c));
      chk($sformatf("col%0d_data", c), 128'(out_data), exp[c]);
      chk($sformatf("col%0d_last", c), 128'(out_last), 128'(c == NCOLS-1));
      chk($sformatf("col%0d_in_ready", c), 128'(in_ready), 128'(0));
      if (c == stall_col && stall_n > 0) begin
        held_col  = out_col;
        held_dat  = out_data;
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk($sformatf("stall%0d_valid", c), 128'(out_valid), 128'(1));
          chk($sformatf("stall%0d_col", c), 128'(out_col), 128'(held_col));
          chk($sformatf("stall%0d_data", c), 128'(out_data), 128'(held_dat));
          chk($sformatf("stall%0d_in_ready", c), 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("done_out_valid", 128'(out_valid), 128'(0));
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
  endtask

  limbs_t la, lb;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;

    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_col", 128'(out_col), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));

    // All zero.
    la = '{default: '0};
    lb = '{default: '0};
    run_op(la, lb, -1, 0, 1'b0);

    // Single unit limb.
    la[0] = 1;
    lb[0] = 1;
    run_op(la, lb, -1, 0, 1'b0);

    // Small ramp against ones; stall at column 3 with in_valid held high.
    la = '{1, 2, 3, 4, 5};
    lb = '{1, 1, 1, 1, 1};
    run_op(la, lb, 3, 4, 1'b1);

    // Maximal limbs: column 4 carries 5 full-width products.
    la = '{default: {LIMB_W{1'b1}}};
    lb = '{default: {LIMB_W{1'b1}}};
    run_op(la, lb, 8, 2, 1'b0);

    // Reset at MAC cycle 10.
    @(negedge clk);
    a_in     = rnd_fe();
    b_in     = rnd_fe();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_out_data", 128'(out_data), 128'(0));

    // Random operations with random stalls.
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < NLIMBS; n++) begin
        la[n] = (t == 7) ? {LIMB_W{1'b1}} : rnd_limb();
        lb[n] = rnd_limb();
      end
      run_op(la, lb, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), t[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
